// File: rtl/fp_div_iter.sv
// Parametrised floating-point divider: radix-2 restoring, one quotient bit per clock,
// round-to-nearest-even, flush-to-zero, IEEE special operands and exception flags.
module fp_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clock,
  input  logic         resetb,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_q,
  output logic [4:0]   out_flags
);

  localparam int QW    = MAN_W + 3;
  localparam int CNT_W = $clog2(QW);

  localparam logic [EXP_W+1:0] BIAS_E   = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [EXP_W+1:0] EMAX_E   = {2'b00, {EXP_W{1'b1}}};
  localparam logic [EXP_W+1:0] ONE_E    = {{(EXP_W+1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [4:0] F_INVALID = 5'b10000;
  localparam logic [4:0] F_DIVZERO = 5'b01000;
  localparam logic [4:0] F_OVF     = 5'b00101;
  localparam logic [4:0] F_UNF     = 5'b00011;
  localparam logic [4:0] F_INEXACT = 5'b00001;

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_NORM, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  logic [EXP_W+1:0]   exp_q, exp_d;
  logic [MAN_W:0]     mb_q, mb_d;
  logic [MAN_W+1:0]   rem_q, rem_d;
  logic [QW-1:0]      quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       result_q, result_d;
  logic [4:0]         flags_q, flags_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, res_sign;
  logic               spec_hit;
  logic [W-1:0]       spec_res;
  logic [4:0]         spec_flags;
  logic               step_ge;
  logic [MAN_W+1:0]   step_rem;
  logic [MAN_W:0]     sig;
  logic [MAN_W+1:0]   sig_r;
  logic               guard, sticky, round_up;
  logic [EXP_W+1:0]   exp_n;
  logic [W-1:0]       norm_res;
  logic [4:0]         norm_flags;

  always_comb begin
    ea       = a_q[W-2:MAN_W];
    eb       = b_q[W-2:MAN_W];
    fa       = a_q[MAN_W-1:0];
    fb       = b_q[MAN_W-1:0];
    res_sign = a_q[W-1] ^ b_q[W-1];
    // Subnormal operands are deliberately classified as zero (flush-to-zero).
    a_zero   = (ea == '0);
    b_zero   = (eb == '0);
    a_inf    = (&ea) && (fa == '0);
    b_inf    = (&eb) && (fb == '0);
    a_nan    = (&ea) && (fa != '0);
    b_nan    = (&eb) && (fb != '0);

    spec_hit   = 1'b1;
    spec_res   = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    spec_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res   = QNAN;
      spec_flags = F_INVALID;
    end else if (a_inf) begin
      spec_flags = '0;
    end else if (b_zero) begin
      spec_flags = F_DIVZERO;
    end else if (a_zero || b_inf) begin
      spec_res   = {res_sign, {(W-1){1'b0}}};
    end else begin
      spec_hit   = 1'b0;
    end

    step_ge  = (rem_q >= {1'b0, mb_q});
    step_rem = step_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

    if (quo_q[QW-1]) begin
      sig    = quo_q[QW-1:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (rem_q != '0);
      exp_n  = exp_q;
    end else begin
      sig    = quo_q[QW-2:1];
      guard  = quo_q[0];
      sticky = (rem_q != '0);
      exp_n  = exp_q - ONE_E;
    end
    round_up = guard && (sticky || sig[0]);
    sig_r    = {1'b0, sig} + {{(MAN_W+1){1'b0}}, round_up};
    if (sig_r[MAN_W+1]) begin
      exp_n = exp_n + ONE_E;
    end
    // exp_n is two's complement; its MSB marks a negative biased exponent.
    if (!exp_n[EXP_W+1] && (exp_n >= EMAX_E)) begin
      norm_res   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      norm_flags = F_OVF;
    end else if (exp_n[EXP_W+1] || (exp_n == '0)) begin
      norm_res   = {sign_q, {(W-1){1'b0}}};
      norm_flags = F_UNF;
    end else begin
      norm_res   = {sign_q, exp_n[EXP_W-1:0], sig_r[MAN_W-1:0]};
      norm_flags = (guard || sticky) ? F_INEXACT : 5'b00000;
    end

    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mb_d        = mb_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    flags_d     = flags_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d        = in_a;
          b_d        = in_b;
          in_ready_d = 1'b0;
          state_d    = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sign_d = res_sign;
        if (spec_hit) begin
          result_d    = spec_res;
          flags_d     = spec_flags;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          exp_d   = {2'b00, ea} - {2'b00, eb} + BIAS_E;
          rem_d   = {2'b01, fa};
          mb_d    = {1'b1, fb};
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        quo_d = {quo_q[QW-2:0], step_ge};
        rem_d = {step_rem[MAN_W:0], 1'b0};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        result_d    = norm_res;
        flags_d     = norm_flags;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mb_q        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mb_q        <= mb_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_q     = result_q;
  assign out_flags = flags_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter (8/23 format): expected results queued at issue,
// popped and checked when the divider presents its result.
module tb_fp_div_iter;

  logic        clock;
  logic        resetb;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_q;
  logic [4:0]  out_flags;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] q;
    logic [4:0]  flags;
    int          lat;
  } exp_t;

  exp_t sb[$];

  fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .clock     (clock),
    .resetb    (resetb),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_flags (out_flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge (cycle 1).
  task automatic driveOperands(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    compare("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_q, input logic [4:0] exp_flags,
                               input int exp_lat);
    exp_t e;
    e.q     = exp_q;
    e.flags = exp_flags;
    e.lat   = exp_lat;
    sb.push_back(e);
    driveOperands(a, b);
  endtask

  // Cycle k is the k-th posedge after acceptance; out_valid is sampled at the negedge before it.
  task automatic checkOutput(input bit consume);
    exp_t e;
    int   k;
    if (sb.size() == 0) begin
      compare("scoreboard_nonempty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    k = 1;
    while (out_valid !== 1'b1 && k < 200) begin
      @(negedge clock);
      k++;
    end
    compare("out_valid_seen", {31'b0, out_valid}, 32'd1);
    compare("latency", 32'(k), 32'(e.lat));
    compare("out_q", out_q, e.q);
    compare("out_flags", {27'b0, out_flags}, {27'b0, e.flags});
    if (consume) begin
      @(negedge clock);
      compare("in_ready_after_take", {31'b0, in_ready}, 32'd1);
      compare("out_valid_after_take", {31'b0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    resetb    = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    compare("reset_in_ready", {31'b0, in_ready}, 32'd1);
    compare("reset_out_valid", {31'b0, out_valid}, 32'd0);
    compare("reset_out_q", out_q, 32'h0);
    compare("reset_out_flags", {27'b0, out_flags}, 32'h0);
    resetb = 1'b1;
    @(negedge clock);

    // Normal divides, including an inexact result rounded up by RNE.
    applyStimulus(32'hC2040000, 32'h40490FDB, 32'hC128114F, 5'b00001, 29); checkOutput(1'b1);
    applyStimulus(32'h3F800000, 32'h40000000, 32'h3F000000, 5'b00000, 29); checkOutput(1'b1);
    applyStimulus(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 29); checkOutput(1'b1);
    applyStimulus(32'hBF800000, 32'h40000000, 32'hBF000000, 5'b00000, 29); checkOutput(1'b1);

    // Special operands resolve in cycle 2.
    applyStimulus(32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 2); checkOutput(1'b1);
    applyStimulus(32'h3F800000, 32'h80000000, 32'hFF800000, 5'b01000, 2); checkOutput(1'b1);
    applyStimulus(32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 2); checkOutput(1'b1);
    applyStimulus(32'hFFC00000, 32'h3F800000, 32'h7FC00000, 5'b10000, 2); checkOutput(1'b1);
    applyStimulus(32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 2); checkOutput(1'b1);
    applyStimulus(32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000, 2); checkOutput(1'b1);
    applyStimulus(32'h3F800000, 32'hFF800000, 32'h80000000, 5'b00000, 2); checkOutput(1'b1);
    applyStimulus(32'h80000000, 32'h40000000, 32'h80000000, 5'b00000, 2); checkOutput(1'b1);
    applyStimulus(32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 2); checkOutput(1'b1);

    // Exponent range limits.
    applyStimulus(32'h7F7FFFFF, 32'h3E800000, 32'h7F800000, 5'b00101, 29); checkOutput(1'b1);
    applyStimulus(32'h00800000, 32'h7F7FFFFF, 32'h00000000, 5'b00011, 29); checkOutput(1'b1);

    // Back-pressure: result held, new operands ignored while busy.
    out_ready = 1'b0;
    applyStimulus(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 29);
    checkOutput(1'b0);
    for (int i = 0; i < 10; i++) begin
      in_a     = 32'h40000000;
      in_b     = 32'h3F800000;
      in_valid = 1'b1;
      @(negedge clock);
      compare("hold_out_valid", {31'b0, out_valid}, 32'd1);
      compare("hold_out_q", out_q, 32'h3EAAAAAB);
      compare("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    compare("release_in_ready", {31'b0, in_ready}, 32'd1);
    compare("release_out_valid", {31'b0, out_valid}, 32'd0);
    repeat (3) @(negedge clock);
    compare("no_ghost_result", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of DIVIDE discards the operation.
    driveOperands(32'h3F800000, 32'h40400000);
    repeat (10) @(negedge clock);
    resetb = 1'b0;
    @(negedge clock);
    resetb = 1'b1;
    compare("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    compare("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    compare("midreset_out_q", out_q, 32'h0);
    compare("midreset_out_flags", {27'b0, out_flags}, 32'h0);
    applyStimulus(32'h40400000, 32'h3F800000, 32'h40400000, 5'b00000, 29); checkOutput(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
